// File: rtl/insn_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : insn_seq_ctrl
//  Description : Multi-cycle instruction sequencer for the pd2 core. Fetches
//                one instruction at a time, steps it through decode, execute,
//                memory access and writeback, and commits the next PC.
//                Illegal opcodes and misaligned targets park in a sticky trap.
//  Revision    : 1.0 - initial release
// ============================================================================
module insn_seq_ctrl #(
   parameter int                 DWIDTH   = 32,
   parameter logic [DWIDTH-1:0]  RESET_PC = 32'h0100_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   // instruction fetch
   output logic              imem_req_o,
   output logic [DWIDTH-1:0] imem_addr_o,
   input  logic              imem_valid_i,
   input  logic [DWIDTH-1:0] imem_data_i,
   // to immediate generator / decoder
   output logic [DWIDTH-1:0] insn_o,
   output logic [6:0]        opcode_o,
   input  logic [31:0]       imm_i,
   // execute inputs
   input  logic [DWIDTH-1:0] alu_res_i,
   input  logic              br_taken_i,
   // data memory
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [DWIDTH-1:0] dmem_addr_o,
   input  logic              dmem_ack_i,
   // writeback / status
   output logic              rf_we_o,
   output logic [1:0]        wb_sel_o,
   output logic [DWIDTH-1:0] pc_o,
   output logic              trap_o,
   output logic [31:0]       retire_cnt_o
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_TRAP   = 3'd5;

   localparam logic [6:0] c_OP_LUI    = 7'h37;
   localparam logic [6:0] c_OP_AUIPC  = 7'h17;
   localparam logic [6:0] c_OP_JAL    = 7'h6F;
   localparam logic [6:0] c_OP_JALR   = 7'h67;
   localparam logic [6:0] c_OP_BRANCH = 7'h63;
   localparam logic [6:0] c_OP_LOAD   = 7'h03;
   localparam logic [6:0] c_OP_STORE  = 7'h23;
   localparam logic [6:0] c_OP_OPIMM  = 7'h13;
   localparam logic [6:0] c_OP_OP     = 7'h33;
   localparam logic [6:0] c_OP_MISC   = 7'h0F;
   localparam logic [6:0] c_OP_SYSTEM = 7'h73;

   localparam logic [DWIDTH-1:0] c_NOP  = DWIDTH'(32'h0000_0013);
   localparam logic [DWIDTH-1:0] c_FOUR = DWIDTH'(4);

   logic [2:0]        state_q, state_d;
   logic [DWIDTH-1:0] pc_q, pc_d;
   logic [DWIDTH-1:0] npc_q, npc_d;
   logic [DWIDTH-1:0] insn_q, insn_d;
   logic [DWIDTH-1:0] daddr_q, daddr_d;
   logic [31:0]       retire_q, retire_d;

   logic [6:0]        w_opcode;
   logic [DWIDTH-1:0] w_imm;
   logic [DWIDTH-1:0] w_target;
   logic              w_legal;
   logic              w_is_mem;
   logic              w_commit_in_exec;
   logic [1:0]        w_wb_sel;

   assign w_opcode = insn_q[6:0];
   assign w_imm    = DWIDTH'($signed(imm_i));

   // Decode the latched opcode: legality, instruction class, writeback source and next-PC target
   always_comb begin
      w_legal          = 1'b0;
      w_is_mem         = 1'b0;
      w_commit_in_exec = 1'b0;
      w_wb_sel         = 2'd0;
      w_target         = pc_q + c_FOUR;
      case (w_opcode)
         c_OP_LUI:    begin w_legal = 1'b1; w_wb_sel = 2'd3; end
         c_OP_AUIPC:  begin w_legal = 1'b1; end
         c_OP_JAL:    begin w_legal = 1'b1; w_wb_sel = 2'd2; w_target = pc_q + w_imm; end
         c_OP_JALR:   begin w_legal = 1'b1; w_wb_sel = 2'd2; w_target = alu_res_i & ~DWIDTH'(1); end
         c_OP_BRANCH: begin
            w_legal          = 1'b1;
            w_commit_in_exec = 1'b1;
            if (br_taken_i) w_target = pc_q + w_imm;
         end
         c_OP_LOAD:   begin w_legal = 1'b1; w_is_mem = 1'b1; w_wb_sel = 2'd1; end
         c_OP_STORE:  begin w_legal = 1'b1; w_is_mem = 1'b1; end
         c_OP_OPIMM:  begin w_legal = 1'b1; end
         c_OP_OP:     begin w_legal = 1'b1; end
         c_OP_MISC:   begin w_legal = 1'b1; w_commit_in_exec = 1'b1; end
         c_OP_SYSTEM: begin w_legal = 1'b1; w_commit_in_exec = 1'b1; end
         default:     begin w_legal = 1'b0; end
      endcase
   end

   // Next-state and datapath update; handshakes are only honoured in the state waiting for them
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      npc_d    = npc_q;
      insn_d   = insn_q;
      daddr_d  = daddr_q;
      retire_d = retire_q;
      case (state_q)
         S_FETCH: begin
            if (imem_valid_i) begin
               insn_d  = imem_data_i;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = w_legal ? S_EXEC : S_TRAP;
         end
         S_EXEC: begin
            if (w_target[1]) begin
               // faulting PC stays in pc_q; nothing is committed
               state_d = S_TRAP;
            end else if (w_is_mem) begin
               npc_d   = w_target;
               daddr_d = alu_res_i;
               state_d = S_MEM;
            end else if (w_commit_in_exec) begin
               pc_d     = w_target;
               retire_d = retire_q + 32'd1;
               state_d  = S_FETCH;
            end else begin
               npc_d   = w_target;
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (dmem_ack_i) begin
               if (w_opcode == c_OP_STORE) begin
                  pc_d     = npc_q;
                  retire_d = retire_q + 32'd1;
                  state_d  = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            pc_d     = npc_q;
            retire_d = retire_q + 32'd1;
            state_d  = S_FETCH;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_TRAP;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         npc_q    <= RESET_PC;
         insn_q   <= c_NOP;
         daddr_q  <= '0;
         retire_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         npc_q    <= npc_d;
         insn_q   <= insn_d;
         daddr_q  <= daddr_d;
         retire_q <= retire_d;
      end
   end

   assign imem_req_o   = (state_q == S_FETCH);
   assign imem_addr_o  = pc_q;
   assign insn_o       = insn_q;
   assign opcode_o     = w_opcode;
   assign dmem_req_o   = (state_q == S_MEM);
   assign dmem_we_o    = (state_q == S_MEM) && (w_opcode == c_OP_STORE);
   assign dmem_addr_o  = daddr_q;
   assign rf_we_o      = (state_q == S_WB);
   assign wb_sel_o     = (state_q == S_TRAP) ? 2'd0 : w_wb_sel;
   assign pc_o         = pc_q;
   assign trap_o       = (state_q == S_TRAP);
   assign retire_cnt_o = retire_q;

endmodule
`default_nettype wire

// File: tb/tb_insn_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_insn_seq_ctrl
//  Description : Directed self-checking bench for insn_seq_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_insn_seq_ctrl;

   localparam logic [31:0] RST_PC = 32'h0100_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid = 1'b0;
   logic [31:0] imem_data = '0;
   logic [31:0] insn;
   logic [6:0]  opcode;
   logic [31:0] imm = '0;
   logic [31:0] alu_res = '0;
   logic        br_taken = 1'b0;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic        dmem_ack = 1'b0;
   logic        rf_we;
   logic [1:0]  wb_sel;
   logic [31:0] pc;
   logic        trap;
   logic [31:0] retire_cnt;

   int total = 0;
   int bad = 0;
   int rf_we_seen = 0;

   insn_seq_ctrl #(.DWIDTH(32), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_o(imem_req), .imem_addr_o(imem_addr),
      .imem_valid_i(imem_valid), .imem_data_i(imem_data),
      .insn_o(insn), .opcode_o(opcode), .imm_i(imm),
      .alu_res_i(alu_res), .br_taken_i(br_taken),
      .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
      .dmem_ack_i(dmem_ack),
      .rf_we_o(rf_we), .wb_sel_o(wb_sel), .pc_o(pc), .trap_o(trap),
      .retire_cnt_o(retire_cnt)
   );

   always #5 clk = ~clk;

   // count register-write pulses away from the active edge
   always @(negedge clk) if (rf_we === 1'b1) rf_we_seen++;

   // hard bound on run time
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // run one zero-wait ALU-class instruction from FETCH back to the next FETCH
   task automatic run_alu(input logic [31:0] i_insn, input logic [31:0] i_imm, input logic [31:0] i_alu);
      imem_valid = 1'b1; imem_data = i_insn; imm = i_imm; alu_res = i_alu;
      tick(); imem_valid = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; imem_valid = 1'b1; imem_data = 32'h0050_0093; dmem_ack = 1'b1;
      tick(); tick();
      rst_n = 1'b1; imem_valid = 1'b0; dmem_ack = 1'b0;
      total++; if (pc !== RST_PC) begin bad++; $display("FAIL rst_pc: got %h want %h", pc, RST_PC); end
      total++; if (insn !== 32'h0000_0013) begin bad++; $display("FAIL rst_insn: got %h want 00000013", insn); end
      total++; if (opcode !== 7'h13) begin bad++; $display("FAIL rst_opcode: got %h want 13", opcode); end
      total++; if ({trap, dmem_req, dmem_we, rf_we} !== 4'b0000) begin bad++; $display("FAIL rst_flags: got %b want 0000", {trap, dmem_req, dmem_we, rf_we}); end
      total++; if (retire_cnt !== 32'd0) begin bad++; $display("FAIL rst_retire: got %0d want 0", retire_cnt); end
      total++; if (wb_sel !== 2'd0) begin bad++; $display("FAIL rst_wbsel: got %0d want 0", wb_sel); end
      total++; if ({imem_req, imem_addr} !== {1'b1, RST_PC}) begin bad++; $display("FAIL rst_fetch: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RST_PC); end
   endtask

   task automatic test_addi();
      imem_valid = 1'b1; imem_data = 32'h0050_0093; imm = 32'd5; alu_res = 32'd5;
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL addi_req: got %b want 1", imem_req); end
      tick(); imem_valid = 1'b0;
      total++; if ({opcode, insn} !== {7'h13, 32'h0050_0093}) begin bad++; $display("FAIL addi_latch: got op=%h insn=%h want op=13 insn=00500093", opcode, insn); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL addi_req_drop: got %b want 0", imem_req); end
      tick();
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL addi_exec_we: got %b want 0", rf_we); end
      tick();
      total++; if ({rf_we, wb_sel} !== {1'b1, 2'd0}) begin bad++; $display("FAIL addi_wb: got we=%b sel=%0d want we=1 sel=0", rf_we, wb_sel); end
      tick();
      total++; if (pc !== 32'h0100_0004) begin bad++; $display("FAIL addi_pc: got %h want 01000004", pc); end
      total++; if (retire_cnt !== 32'd1) begin bad++; $display("FAIL addi_retire: got %0d want 1", retire_cnt); end
      total++; if ({rf_we, imem_req} !== 2'b01) begin bad++; $display("FAIL addi_refetch: got we=%b req=%b want we=0 req=1", rf_we, imem_req); end
   endtask

   task automatic test_load();
      imem_valid = 1'b1; imem_data = 32'h0040_A103; imm = 32'd4; alu_res = 32'h0000_1004;
      tick(); imem_valid = 1'b0;
      tick();
      tick(); alu_res = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) dmem_ack = 1'b1;
         total++;
         if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, 32'h0000_1004}) begin
            bad++; $display("FAIL lw_mem%0d: got req=%b we=%b addr=%h want req=1 we=0 addr=00001004", i, dmem_req, dmem_we, dmem_addr);
         end
         tick();
      end
      dmem_ack = 1'b0;
      total++; if ({rf_we, wb_sel, dmem_req} !== {1'b1, 2'd1, 1'b0}) begin bad++; $display("FAIL lw_wb: got we=%b sel=%0d req=%b want we=1 sel=1 req=0", rf_we, wb_sel, dmem_req); end
      tick();
      total++; if ({pc, retire_cnt} !== {32'h0100_0008, 32'd2}) begin bad++; $display("FAIL lw_commit: got pc=%h ret=%0d want pc=01000008 ret=2", pc, retire_cnt); end
   endtask

   task automatic test_store();
      int seen;
      seen = rf_we_seen;
      imem_valid = 1'b1; imem_data = 32'h0020_A423; imm = 32'd8; alu_res = 32'h0000_2008;
      tick(); imem_valid = 1'b0;
      tick(); tick();
      dmem_ack = 1'b1;
      total++; if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b1, 32'h0000_2008}) begin bad++; $display("FAIL sw_mem: got req=%b we=%b addr=%h want req=1 we=1 addr=00002008", dmem_req, dmem_we, dmem_addr); end
      tick(); dmem_ack = 1'b0;
      total++; if ({pc, retire_cnt} !== {32'h0100_000C, 32'd3}) begin bad++; $display("FAIL sw_commit: got pc=%h ret=%0d want pc=0100000c ret=3", pc, retire_cnt); end
      total++; if ({dmem_req, imem_req} !== 2'b01) begin bad++; $display("FAIL sw_refetch: got dreq=%b ireq=%b want dreq=0 ireq=1", dmem_req, imem_req); end
      total++; if (rf_we_seen !== seen) begin bad++; $display("FAIL sw_no_rfwe: got %0d pulses want %0d", rf_we_seen, seen); end
   endtask

   task automatic test_branch();
      int seen;
      run_alu(32'h0000_0013, 32'd0, 32'd0);
      seen = rf_we_seen;
      imem_valid = 1'b1; imem_data = 32'hFE20_8CE3; imm = 32'hFFFF_FFF8; br_taken = 1'b1;
      tick(); imem_valid = 1'b0;
      tick(); tick();
      total++; if ({pc, retire_cnt} !== {32'h0100_0008, 32'd5}) begin bad++; $display("FAIL beq_taken: got pc=%h ret=%0d want pc=01000008 ret=5", pc, retire_cnt); end
      run_alu(32'h0000_0013, 32'd0, 32'd0);
      run_alu(32'h0000_0013, 32'd0, 32'd0);
      imem_valid = 1'b1; imem_data = 32'hFE20_8CE3; imm = 32'hFFFF_FFF8; br_taken = 1'b0;
      tick(); imem_valid = 1'b0;
      tick(); tick();
      total++; if ({pc, retire_cnt} !== {32'h0100_0014, 32'd8}) begin bad++; $display("FAIL beq_not_taken: got pc=%h ret=%0d want pc=01000014 ret=8", pc, retire_cnt); end
      total++; if (rf_we_seen !== seen + 2) begin bad++; $display("FAIL beq_no_rfwe: got %0d pulses want %0d", rf_we_seen, seen + 2); end
   endtask

   task automatic test_jump_wrap();
      imem_valid = 1'b1; imem_data = 32'h0000_80E7; imm = 32'd0; alu_res = 32'hFFFF_FFFD;
      tick(); imem_valid = 1'b0;
      tick(); tick();
      total++; if ({rf_we, wb_sel} !== {1'b1, 2'd2}) begin bad++; $display("FAIL jalr_wb: got we=%b sel=%0d want we=1 sel=2", rf_we, wb_sel); end
      tick();
      total++; if ({pc, retire_cnt} !== {32'hFFFF_FFFC, 32'd9}) begin bad++; $display("FAIL jalr_pc: got pc=%h ret=%0d want pc=fffffffc ret=9", pc, retire_cnt); end
      imem_valid = 1'b1; imem_data = 32'h1234_50B7; imm = 32'h1234_5000;
      tick(); imem_valid = 1'b0;
      tick(); tick();
      total++; if ({rf_we, wb_sel} !== {1'b1, 2'd3}) begin bad++; $display("FAIL lui_wb: got we=%b sel=%0d want we=1 sel=3", rf_we, wb_sel); end
      tick();
      total++; if ({pc, retire_cnt} !== {32'h0000_0000, 32'd10}) begin bad++; $display("FAIL pc_wrap: got pc=%h ret=%0d want pc=00000000 ret=10", pc, retire_cnt); end
   endtask

   task automatic test_jalr_trap();
      imem_valid = 1'b1; imem_data = 32'h0000_80E7; imm = 32'd0; alu_res = 32'h0000_2003;
      tick(); imem_valid = 1'b0;
      tick(); tick();
      total++; if ({trap, pc, retire_cnt} !== {1'b1, 32'h0, 32'd10}) begin bad++; $display("FAIL jalr_trap: got trap=%b pc=%h ret=%0d want trap=1 pc=00000000 ret=10", trap, pc, retire_cnt); end
      imem_valid = 1'b1; dmem_ack = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if ({imem_req, dmem_req, rf_we, trap, pc} !== {4'b0001, 32'h0}) begin
            bad++; $display("FAIL trap_hold%0d: got ireq=%b dreq=%b we=%b trap=%b pc=%h want 0 0 0 1 00000000", i, imem_req, dmem_req, rf_we, trap, pc);
         end
      end
      imem_valid = 1'b0; dmem_ack = 1'b0;
   endtask

   task automatic test_illegal();
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      imem_valid = 1'b1; imem_data = 32'h0000_007F;
      tick(); imem_valid = 1'b0;
      total++; if (trap !== 1'b0) begin bad++; $display("FAIL ill_decode: got trap=%b want 0", trap); end
      tick();
      total++; if ({trap, pc, imem_req} !== {1'b1, RST_PC, 1'b0}) begin bad++; $display("FAIL ill_trap: got trap=%b pc=%h req=%b want trap=1 pc=%h req=0", trap, pc, imem_req, RST_PC); end
      tick();
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      total++; if ({trap, pc, imem_req, retire_cnt} !== {1'b0, RST_PC, 1'b1, 32'd0}) begin bad++; $display("FAIL ill_recover: got trap=%b pc=%h req=%b ret=%0d want trap=0 pc=%h req=1 ret=0", trap, pc, imem_req, retire_cnt, RST_PC); end
   endtask

   task automatic test_reset_mid_mem();
      int seen;
      imem_valid = 1'b1; imem_data = 32'h0040_A103; imm = 32'd4; alu_res = 32'h0000_3000;
      tick(); imem_valid = 1'b0;
      tick(); tick();
      total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL mid_mem_req: got %b want 1", dmem_req); end
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      total++; if ({dmem_req, imem_req} !== 2'b01) begin bad++; $display("FAIL mid_mem_drop: got dreq=%b ireq=%b want dreq=0 ireq=1", dmem_req, imem_req); end
      seen = rf_we_seen;
      dmem_ack = 1'b1; tick(); dmem_ack = 1'b0;
      tick(); tick();
      total++; if (rf_we_seen !== seen) begin bad++; $display("FAIL stray_ack_we: got %0d pulses want %0d", rf_we_seen, seen); end
      total++; if ({retire_cnt, pc, dmem_req, imem_req} !== {32'd0, RST_PC, 2'b01}) begin bad++; $display("FAIL stray_ack_state: got ret=%0d pc=%h dreq=%b ireq=%b want ret=0 pc=%h dreq=0 ireq=1", retire_cnt, pc, dmem_req, imem_req, RST_PC); end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_load();
      test_store();
      test_branch();
      test_jump_wrap();
      test_jalr_trap();
      test_illegal();
      test_reset_mid_mem();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
